// File: rtl/byte_to_ascii_hex_pkg.sv
// byte_to_ascii_hex_pkg: shared state encoding and ASCII constants for the byte-to-hex converter.
package byte_to_ascii_hex_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND_HIGH = 2'b01,
        SEND_LOW  = 2'b10,
        SEND_SEP  = 2'b11
    } state_t;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] UPPER_A = 8'h41;
    localparam logic [7:0] LOWER_A = 8'h61;
endpackage

// File: rtl/byte_to_ascii_hex_if.sv
// byte_to_ascii_hex_if: upstream byte handshake and downstream character handshake.
interface byte_to_ascii_hex_if;
    logic       data_valid;
    logic [7:0] data_in;
    logic       ready;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    modport slave (input data_valid, data_in, tx_ready, output ready, tx_valid, tx_byte);
    modport master (output data_valid, data_in, tx_ready, input ready, tx_valid, tx_byte);
endinterface

// File: rtl/byte_to_ascii_hex_nibble_to_ascii.sv
// nibble_to_ascii: maps one 4-bit value to its ASCII hex digit.
module nibble_to_ascii
    import byte_to_ascii_hex_pkg::*;
#(
    parameter bit UPPER_CASE = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);
    assign o_ascii = (i_nibble < 4'd10) ? ZERO + 8'(i_nibble)
                                        : (UPPER_CASE ? UPPER_A : LOWER_A) + 8'(i_nibble) - 8'd10;
endmodule

// File: rtl/byte_to_ascii_hex.sv
// byte_to_ascii_hex: emits each accepted byte as two ASCII hex characters plus an optional separator.
module byte_to_ascii_hex
    import byte_to_ascii_hex_pkg::*;
#(
    parameter bit         UPPER_CASE = 1'b1,
    parameter logic [7:0] SEPARATOR  = 8'h00
) (
    input logic clk,
    input logic reset,
    byte_to_ascii_hex_if.slave bus
);
    state_t     r_state, w_next;
    logic [7:0] r_data, r_tx_byte, w_byte, w_ascii, w_tx_byte;
    logic       r_tx_valid, w_accept, w_done;
    logic [3:0] w_nibble;

    assign w_accept = bus.data_valid && (r_state == IDLE);
    assign w_done   = r_tx_valid && bus.tx_ready;
    // Outputs are registered, so the character is chosen for the state being entered.
    assign w_byte   = (r_state == IDLE) ? bus.data_in : r_data;
    assign w_nibble = (w_next == SEND_HIGH) ? w_byte[7:4] : w_byte[3:0];

    nibble_to_ascii #(.UPPER_CASE(UPPER_CASE)) u_nib (
        .i_nibble(w_nibble),
        .o_ascii (w_ascii)
    );

    always_comb begin
        w_next    = r_state;
        w_tx_byte = r_tx_byte;
        if (r_state == IDLE)
            w_next = w_accept ? SEND_HIGH : IDLE;
        else if (w_done)
            w_next = (r_state == SEND_HIGH) ? SEND_LOW :
                     (r_state == SEND_LOW && SEPARATOR != 8'h00) ? SEND_SEP : IDLE;
        if (w_next != r_state && (w_next == SEND_HIGH || w_next == SEND_LOW))
            w_tx_byte = w_ascii;
        else if (w_next == SEND_SEP)
            w_tx_byte = SEPARATOR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            r_state    <= w_next;
            if (w_accept)
                r_data <= bus.data_in;
            r_tx_valid <= (w_next != IDLE);
            r_tx_byte  <= w_tx_byte;
        end
    end

    assign bus.ready    = (r_state == IDLE);
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_byte  = r_tx_byte;
endmodule

// File: doc/byte_to_ascii_hex.md
# byte_to_ascii_hex

- Converts each 8-bit value from the FPGA datapath into two ASCII hex characters, most-significant nibble first, optionally followed by one separator character.
- Feeds the UART transmit path, so host-bound results arrive in the same text form the host uses for commands.
- Upstream and downstream are both valid/ready handshakes.
- Accepts one byte at a time and applies back-pressure while its characters are being emitted.

## Interface
Parameters:
- UPPER_CASE, 1: 1 emits "A"–"F" (0x41–0x46); 0 emits "a"–"f" (0x61–0x66).
- SEPARATOR, 8'h00: character sent after the low nibble; 8'h00 disables the separator state.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- data_valid  in  1  upstream has a byte on data_in.
- data_in  in  8  byte to convert.
- ready  out  1  block can accept a byte this cycle.
- tx_valid  out  1  tx_byte holds a character for the UART transmitter.
- tx_byte  out  8  ASCII character.
- tx_ready  in  1  UART transmitter accepts tx_byte this cycle.

## Operation
States: IDLE, SEND_HIGH, SEND_LOW, SEND_SEP.

- **IDLE**
  - ready=1, tx_valid=0.
  - Upstream transfer occurs when data_valid && ready: latch data_in and go to SEND_HIGH.
- **SEND_HIGH**
  - tx_valid=1, tx_byte=ascii(data[7:4]).
  - On tx_valid && tx_ready, go to SEND_LOW.
- **SEND_LOW**
  - tx_valid=1, tx_byte=ascii(data[3:0]).
  - On transfer, go to SEND_SEP if SEPARATOR != 0, else IDLE.
- **SEND_SEP**
  - tx_valid=1, tx_byte=SEPARATOR.
  - On transfer, go to IDLE.

Rules:
- Nibble mapping: 0–9 -> 0x30–0x39; 10–15 -> "A"–"F" or "a"–"f" per UPPER_CASE. Every nibble value is legal, so there is no error path.
- ready = (state == IDLE), decoded from the state register; there is no combinational path from any input.
- data_valid while ready=0 is ignored, not queued. Upstream holds data_valid/data_in until it sees ready.
- tx_byte and tx_valid are registered.
- tx_byte stays stable while tx_valid=1 && tx_ready=0.
- tx_byte does not change until a transfer occurs.
- tx_ready is a don't-care while tx_valid=0.

Reset:
- All state and outputs take reset values on the cycle after reset is sampled high: state=IDLE, tx_valid=0, tx_byte=8'h00, latched byte=8'h00, ready=1.
- Reset mid-operation discards the pending characters.
- No partial character is re-sent after reset.
- reset takes priority over data_valid and tx_ready in the same cycle.

## Timing
- A byte accepted at edge N gives tx_valid=1 with the high-nibble character from edge N.
- The character transfers at the first edge M ≥ N+1 where tx_ready=1; the low-nibble character is presented from edge M.
- With tx_ready held at 1 and no separator:
  - characters transfer at edges N+1 and N+2;
  - ready returns high at edge N+2;
  - the next byte can be accepted at edge N+3.
- Minimum period is 3 cycles per byte without a separator and 4 cycles with one.
- No back-to-back overlap between bytes.
- tx_valid never drops between the characters of one byte while tx_ready stalls.

## Structure
- Shared package contents:
  - state enumeration (2-bit: IDLE=00, SEND_HIGH=01, SEND_LOW=10, SEND_SEP=11);
  - ASCII constants ZERO=0x30, UPPER_A=0x41, LOWER_A=0x61.
- One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out, parameter UPPER_CASE), instantiated once. Its input mux selects data[7:4] or data[3:0] by state.
- The FSM, data latch and output registers live in byte_to_ascii_hex.

## Test plan
- UPPER_CASE=1, SEPARATOR=0, tx_ready=1, send 0x3C:
  - tx_byte 0x33 then 0x43 on consecutive cycles;
  - ready low for 2 cycles, then high.
- UPPER_CASE=0, send 0xAF -> 0x61, 0x66. With UPPER_CASE=1, same byte -> 0x41, 0x46.
- Send 0x7E with tx_ready held 0 for 5 cycles, then 1:
  - tx_valid=1 and tx_byte=0x37 stable throughout;
  - then 0x45 follows;
  - exactly 2 characters total.
- SEPARATOR=0x20, send 0x00 then 0xFF with data_valid held:
  - characters 0x30, 0x30, 0x20, 0x46, 0x46, 0x20;
  - second byte accepted only when ready=1.
- Assert data_valid with 0x99 while in SEND_LOW of 0x12:
  - output stays 0x31, 0x32;
  - 0x99 accepted only after return to IDLE.
- Pulse reset one cycle after 0x5A's first character (0x35) transfers:
  - next cycle tx_valid=0, tx_byte=0x00, ready=1;
  - no 0x41 emitted;
  - next byte 0xB4 yields 0x42, 0x34.
